capture_buffer: RTL and testbench
=================================

Name: capture_buffer

Overview:
- Receiving end of the trigger output stream: consumes {event, data} samples from the trigger block and keeps pre-trigger history in a circular buffer.
- After the trigger event it captures a programmed number of post-trigger samples, then unloads the whole window as an output stream with tlast.
- Configured over the same write-only system bus as the trigger, selected by its own bus_wselct bit.

Parameters:
BAW, 8, system bus address width
BDW, 32, system bus data width
SDW, 32, sample data width
SEW, 2, sample event width (bit 0 is the trigger event)
CAW, 6, capture buffer address width; depth D = 2**CAW

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
bus_wready  output  1  bus write ready
bus_wvalid  input  1  bus write valid
bus_waddr  input  BAW  bus write address
bus_wdata  input  BDW  bus write data
bus_wselct  input  4  bus block select; this block responds to bit 2
sti_tready  output  1  input stream ready
sti_tvalid  input  1  input stream valid
sti_tevent  input  SEW  input sample events
sti_tdata  input  SDW  input sample data
sto_tready  input  1  readout stream ready
sto_tvalid  output  1  readout stream valid
sto_tlast  output  1  last sample of captured window
sto_tdata  output  SDW  readout sample data
sts_armed  output  1  high in PRE and POST
sts_done  output  1  one-cycle pulse when the last readout sample transfers

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. Reset forces IDLE, pointers and counters 0, sto_tvalid/sto_tlast/sts_armed/sts_done 0, sto_tdata 0. bus_wready is constant 1.
- Bus write: a write is accepted when bus_wvalid & bus_wselct[2].
  - waddr 0 (CTRL): bit0 = arm, bit1 = abort. Abort has priority over arm in the same write.
  - waddr 1 (POST): post-trigger sample count; bits [CAW-1:0] are used; values above D-1 clamp to D-1.
  - Other addresses are ignored.
- Sample transfer: occurs on sti_tvalid & sti_tready.
  - sti_tready = 1 in IDLE, PRE and POST; 0 in READ.
  - In IDLE, samples are accepted and discarded, so upstream never stalls.
- States:
  - IDLE: arm -> PRE, with wptr = 0, fill = 0.
  - PRE: each transfer writes sti_tdata at wptr; wptr increments modulo D; fill saturates at D.
    - If the transferred sample has sti_tevent[0] = 1, it is stored and the state goes to POST with cnt = POST.
    - If POST = 0, the state goes directly to READ instead.
  - POST: each transfer is stored as in PRE and decrements cnt. The transfer that makes cnt reach 0 moves the state to READ. sti_tevent is ignored in POST.
  - READ: rptr starts at (wptr - fill) mod D. Exactly fill samples are emitted in write order. sto_tlast is high on the final one. The final transfer pulses sts_done and returns to IDLE.
- Readout timing:
  - The buffer is a synchronous-read RAM.
  - The first sto_tvalid is asserted no later than 2 cycles after entering READ.
  - Throughput is 1 sample per cycle while sto_tready = 1.
  - While sto_tvalid & !sto_tready, sto_tdata and sto_tlast are held stable, with no loss or duplication.
- Abort: from any state, returns to IDLE on the next clock. It deasserts sto_tvalid and sts_armed and produces no sts_done.
- Arm received in PRE, POST or READ restarts PRE with wptr = 0 and fill = 0, and drops any readout in progress.
- Simultaneous events:
  - A bus CTRL write in the same cycle as a sample transfer: the sample is handled in the old state, then the control action applies.
  - A POST write takes effect at the next arm; it does not alter a POST count already in progress.
- Width and wrap:
  - wptr and rptr are CAW bits and wrap naturally.
  - fill is CAW+1 bits.
  - Clamping POST to D-1 guarantees the trigger sample is always inside the captured window.

Test Plan:
- Order / window: POST = 3, arm, send data 0..9 with event on sample 5 -> readout 0..8; tlast on 8; sample 9 stalls during READ and is discarded in IDLE afterwards.
- Wrap: POST = 4, arm, send data 0..99 with event on 80 -> 64 samples 21..84 read out in order; tlast on 84; sts_done pulses once.
- Zero post: POST = 0, arm, event on first sample (data 0xA5) -> single readout 0xA5 with tlast = 1.
- Clamp: POST = 200, arm, 300 samples with event on 10 -> 64 samples 10..73 read out; trigger sample 10 is first.
- Backpressure: scenario 1 with sto_tready toggling every cycle -> identical 0..8 sequence; tdata stable while stalled; no duplicates.
- Abort / reset: abort during POST -> sto_tvalid never asserts, sts_armed = 0 next cycle. rst low mid-readout -> all outputs 0 immediately; re-arm then repeats scenario 1 correctly.

Source files
------------

// File: rtl/capture_buffer_if.sv
// Signal bundle of the capture buffer: configuration bus, sample input stream,
// readout stream and status flags.
interface capture_buffer_if #(
    parameter int BAW = 8,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2
);
    logic           bus_wready;
    logic           bus_wvalid;
    logic [BAW-1:0] bus_waddr;
    logic [BDW-1:0] bus_wdata;
    logic [3:0]     bus_wselct;

    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;

    logic           sto_tready;
    logic           sto_tvalid;
    logic           sto_tlast;
    logic [SDW-1:0] sto_tdata;

    logic           sts_armed;
    logic           sts_done;

    modport slave (
        output bus_wready,
        input  bus_wvalid, bus_waddr, bus_wdata, bus_wselct,
        output sti_tready,
        input  sti_tvalid, sti_tevent, sti_tdata,
        input  sto_tready,
        output sto_tvalid, sto_tlast, sto_tdata,
        output sts_armed, sts_done
    );

    modport master (
        input  bus_wready,
        output bus_wvalid, bus_waddr, bus_wdata, bus_wselct,
        input  sti_tready,
        output sti_tvalid, sti_tevent, sti_tdata,
        output sto_tready,
        input  sto_tvalid, sto_tlast, sto_tdata,
        input  sts_armed, sts_done
    );
endinterface

// File: rtl/capture_buffer.sv
// Trigger capture buffer: circular pre-trigger history, programmed post-trigger
// capture, then in-order readout of the whole window with tlast.
module capture_buffer #(
    parameter int BAW = 8,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int CAW = 6
) (
    input  logic             clk,
    input  logic             rst,
    capture_buffer_if.slave  io
);
    localparam int D = 2**CAW;
    localparam logic [CAW:0] FULL = (CAW+1)'(D);

    typedef enum logic [1:0] {IDLE, PRE, POST, READ} state_t;

    state_t         state, state_nxt;
    logic [CAW-1:0] wptr, wptr_nxt;
    logic [CAW-1:0] rptr, rptr_nxt;
    logic [CAW-1:0] cnt, cnt_nxt;
    logic [CAW-1:0] post_cfg, post_cfg_nxt;
    logic [CAW-1:0] post_arm, post_arm_nxt;
    logic [CAW:0]   fill, fill_nxt;
    logic [CAW:0]   remain, remain_nxt;
    logic           primed, primed_nxt;
    logic           out_valid, out_valid_nxt;
    logic           out_last, out_last_nxt;
    logic [SDW-1:0] out_data, out_data_nxt;
    logic           done, done_nxt;
    logic           enter_read;

    logic [SDW-1:0] mem [D];
    logic [SDW-1:0] ram_q;

    logic bus_wr, ctrl_wr, post_wr, arm, abort;
    logic xfer, wr_en, consume, load;
    logic [CAW-1:0] post_clamped;
    logic unused_ok;

    assign bus_wr  = io.bus_wvalid & io.bus_wselct[2];
    assign ctrl_wr = bus_wr & (io.bus_waddr == BAW'(0));
    assign post_wr = bus_wr & (io.bus_waddr == BAW'(1));
    assign abort   = ctrl_wr & io.bus_wdata[1];
    assign arm     = ctrl_wr & io.bus_wdata[0];

    // Any set bit above the address range means the count exceeds D-1.
    assign post_clamped = (|io.bus_wdata[BDW-1:CAW]) ? {CAW{1'b1}} : io.bus_wdata[CAW-1:0];

    assign xfer    = io.sti_tvalid & io.sti_tready;
    assign wr_en   = xfer & ((state == PRE) | (state == POST));
    assign consume = out_valid & io.sto_tready;
    assign load    = (state == READ) & primed & (remain != '0) & (~out_valid | io.sto_tready);

    assign unused_ok = ^{io.bus_wselct[3], io.bus_wselct[1:0], io.sti_tevent[SEW-1:1]};

    always_comb begin
        state_nxt     = state;
        wptr_nxt      = wptr;
        rptr_nxt      = rptr;
        cnt_nxt       = cnt;
        fill_nxt      = fill;
        remain_nxt    = remain;
        primed_nxt    = primed;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        out_data_nxt  = out_data;
        post_cfg_nxt  = post_cfg;
        post_arm_nxt  = post_arm;
        done_nxt      = 1'b0;
        enter_read    = 1'b0;

        if (post_wr) begin
            post_cfg_nxt = post_clamped;
        end

        case (state)
            PRE, POST: begin
                if (xfer) begin
                    wptr_nxt = wptr + 1'b1;
                    if (fill != FULL) begin
                        fill_nxt = fill + 1'b1;
                    end
                    if (state == PRE) begin
                        if (io.sti_tevent[0]) begin
                            if (post_arm == '0) begin
                                enter_read = 1'b1;
                            end else begin
                                state_nxt = POST;
                                cnt_nxt   = post_arm;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == CAW'(1)) begin
                            enter_read = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                // ram_q is only trusted one cycle after entry, once the last write has settled.
                primed_nxt = 1'b1;
                if (consume) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                end
                if (load) begin
                    out_data_nxt  = ram_q;
                    out_last_nxt  = (remain == (CAW+1)'(1));
                    out_valid_nxt = 1'b1;
                    remain_nxt    = remain - 1'b1;
                    rptr_nxt      = rptr + 1'b1;
                end
                if (consume & out_last) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    done_nxt      = 1'b1;
                end
            end
            default: ;
        endcase

        if (enter_read) begin
            state_nxt  = READ;
            rptr_nxt   = wptr_nxt - fill_nxt[CAW-1:0];
            remain_nxt = fill_nxt;
            primed_nxt = 1'b0;
        end

        // Control applies after the sample has been handled in the old state.
        if (abort) begin
            state_nxt     = IDLE;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            done_nxt      = 1'b0;
        end else if (arm) begin
            state_nxt     = PRE;
            wptr_nxt      = '0;
            fill_nxt      = '0;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            done_nxt      = 1'b0;
            post_arm_nxt  = post_cfg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            fill      <= '0;
            remain    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            post_cfg  <= '0;
            post_arm  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            cnt       <= cnt_nxt;
            fill      <= fill_nxt;
            remain    <= remain_nxt;
            primed    <= primed_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            out_data  <= out_data_nxt;
            post_cfg  <= post_cfg_nxt;
            post_arm  <= post_arm_nxt;
            done      <= done_nxt;
        end
    end

    // Reading at the next pointer keeps ram_q equal to mem[rptr] every cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= io.sti_tdata;
        end
        ram_q <= mem[rptr_nxt];
    end

    assign io.bus_wready = 1'b1;
    assign io.sti_tready = (state != READ);
    assign io.sto_tvalid = out_valid;
    assign io.sto_tlast  = out_last;
    assign io.sto_tdata  = out_data;
    assign io.sts_armed  = (state == PRE) | (state == POST);
    assign io.sts_done   = done;
endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: directed capture scenarios push the expected
// window, a monitor pops and compares every readout transfer.
module tb_capture_buffer;
    localparam int SDW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    capture_buffer_if cb_if ();

    capture_buffer dut (
        .clk (clk),
        .rst (rst),
        .io  (cb_if.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_count   = 0;
    int pop_count    = 0;
    int valid_count  = 0;
    bit toggle_ready = 1'b0;

    logic [SDW:0]   exp_q[$];
    bit             prev_stall = 1'b0;
    logic [SDW-1:0] prev_data  = '0;
    logic           prev_last  = 1'b0;

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Readout sink: steady ready, or toggling every cycle for backpressure.
    initial begin
        cb_if.sto_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cb_if.sto_tready = toggle_ready ? ~cb_if.sto_tready : 1'b1;
        end
    end

    initial begin : monitor
        logic [SDW:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (cb_if.sto_tvalid) valid_count++;
                if (prev_stall) begin
                    checkOutput("hold_valid", cb_if.sto_tvalid, 1);
                    checkOutput("hold_data", cb_if.sto_tdata, prev_data);
                    checkOutput("hold_last", cb_if.sto_tlast, prev_last);
                end
                if (cb_if.sto_tvalid && cb_if.sto_tready) begin
                    checkOutput("queue_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        checkOutput("rd_data", cb_if.sto_tdata, exp[SDW-1:0]);
                        checkOutput("rd_last", cb_if.sto_tlast, exp[SDW]);
                        pop_count++;
                    end
                end
                if (cb_if.sts_done) done_count++;
                prev_stall = cb_if.sto_tvalid && !cb_if.sto_tready;
                prev_data  = cb_if.sto_tdata;
                prev_last  = cb_if.sto_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
        cb_if.bus_wvalid = 1'b1;
        cb_if.bus_wselct = 4'b0100;
        cb_if.bus_waddr  = addr;
        cb_if.bus_wdata  = data;
        @(posedge clk);
        #1;
        cb_if.bus_wvalid = 1'b0;
        cb_if.bus_wselct = 4'b0000;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic ev);
        bit ok = 1'b0;
        cb_if.sti_tvalid = 1'b1;
        cb_if.sti_tdata  = data;
        cb_if.sti_tevent = {1'b0, ev};
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = cb_if.sti_tready;
            @(posedge clk);
            #1;
        end
        cb_if.sti_tvalid = 1'b0;
        cb_if.sti_tevent = '0;
        if (!ok) checkOutput("sample_accept", ok, 1);
    endtask

    task automatic pushWindow(input int first, input int last);
        for (int v = first; v <= last; v++) begin
            exp_q.push_back({v == last, 32'(v)});
        end
    endtask

    task automatic finishCapture(input int d0, input string name);
        for (int i = 0; i < 600 && done_count == d0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_done_once"}, done_count - d0, 1);
        checkOutput({name, "_window_drained"}, exp_q.size(), 0);
        checkOutput({name, "_armed_low"}, cb_if.sts_armed, 0);
    endtask

    task automatic runCapture(input int post, input int n, input int trig,
                              input int first, input int last, input string name);
        int d0 = done_count;
        busWrite(8'd1, 32'(post));
        busWrite(8'd0, 32'h1);
        checkOutput({name, "_armed"}, cb_if.sts_armed, 1);
        pushWindow(first, last);
        for (int i = 0; i < n; i++) applyStimulus(32'(i), i == trig);
        finishCapture(d0, name);
    endtask

    initial begin
        int d0, v0, p0;
        cb_if.bus_wvalid = 1'b0;
        cb_if.bus_waddr  = '0;
        cb_if.bus_wdata  = '0;
        cb_if.bus_wselct = '0;
        cb_if.sti_tvalid = 1'b0;
        cb_if.sti_tevent = '0;
        cb_if.sti_tdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tvalid", cb_if.sto_tvalid, 0);
        checkOutput("reset_tlast", cb_if.sto_tlast, 0);
        checkOutput("reset_tdata", cb_if.sto_tdata, 0);
        checkOutput("reset_armed", cb_if.sts_armed, 0);
        checkOutput("reset_done", cb_if.sts_done, 0);
        checkOutput("reset_wready", cb_if.bus_wready, 1);
        checkOutput("reset_sti_ready", cb_if.sti_tready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        runCapture(3, 10, 5, 0, 8, "order");
        runCapture(4, 100, 80, 21, 84, "wrap");

        d0 = done_count;
        busWrite(8'd1, 32'd0);
        busWrite(8'd0, 32'h1);
        exp_q.push_back({1'b1, 32'hA5});
        applyStimulus(32'hA5, 1'b1);
        finishCapture(d0, "zero_post");

        runCapture(200, 300, 10, 10, 73, "clamp");

        toggle_ready = 1'b1;
        runCapture(3, 10, 5, 0, 8, "backpressure");
        toggle_ready = 1'b0;

        // Abort during POST, issued together with arm to exercise abort priority.
        d0 = done_count;
        busWrite(8'd1, 32'd5);
        busWrite(8'd0, 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(32'(i), i == 2);
        checkOutput("abort_armed_before", cb_if.sts_armed, 1);
        busWrite(8'd0, 32'h3);
        checkOutput("abort_armed_after", cb_if.sts_armed, 0);
        v0 = valid_count;
        for (int i = 0; i < 20; i++) applyStimulus(32'(100 + i), 1'b1);
        checkOutput("abort_no_valid", valid_count - v0, 0);
        checkOutput("abort_no_done", done_count - d0, 0);
        checkOutput("abort_idle_ready", cb_if.sti_tready, 1);

        // Reset in the middle of a readout, then the basic capture again.
        busWrite(8'd1, 32'd3);
        busWrite(8'd0, 32'h1);
        pushWindow(0, 8);
        for (int i = 0; i < 9; i++) applyStimulus(32'(i), i == 5);
        p0 = pop_count;
        for (int i = 0; i < 100 && pop_count < p0 + 3; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midread_progress", pop_count >= p0 + 3, 1);
        rst = 1'b0;
        #1;
        checkOutput("midread_rst_tvalid", cb_if.sto_tvalid, 0);
        checkOutput("midread_rst_tlast", cb_if.sto_tlast, 0);
        checkOutput("midread_rst_tdata", cb_if.sto_tdata, 0);
        checkOutput("midread_rst_armed", cb_if.sts_armed, 0);
        checkOutput("midread_rst_done", cb_if.sts_done, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        runCapture(3, 10, 5, 0, 8, "rearm");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
